// File: rtl/uc_pkg.sv
// uc_pkg: shared states, opcode fields, selector codes and instruction classifier
package uc_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {K_ADD, K_SUB, K_ADDI, K_LD, K_SD, K_BEQ, K_EBRK, K_ILL} kind_t;
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_D = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [1:0] SEL_B = 2'd0;
  localparam logic [1:0] SEL_A = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // Map a raw instruction word onto the small set of operations the unit executes
  function automatic kind_t classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    return (w == EBREAK) ? K_EBRK :
           (op == OPC_R && f3 == F3_ADD && f7 == F7_ADD) ? K_ADD :
           (op == OPC_R && f3 == F3_ADD && f7 == F7_SUB) ? K_SUB :
           (op == OPC_I && f3 == F3_ADD) ? K_ADDI :
           (op == OPC_LD && f3 == F3_D) ? K_LD :
           (op == OPC_ST && f3 == F3_D) ? K_SD :
           (op == OPC_BR && f3 == F3_BEQ) ? K_BEQ : K_ILL;
  endfunction
endpackage

// File: rtl/uc_multiciclo_gerador_imediato.sv
// gerador_imediato: sign-extended I/S/B immediates from the instruction register fields
module gerador_imediato #(
  parameter int XLEN = 64
) (
  input  logic [11:0]     i_hi,
  input  logic [4:0]      i_lo,
  output logic [XLEN-1:0] o_imm_i,
  output logic [XLEN-1:0] o_imm_s,
  output logic [XLEN-1:0] o_imm_b
);
  // i_hi carries instruction bits 31:20, i_lo carries bits 11:7
  assign o_imm_i = {{(XLEN-12){i_hi[11]}}, i_hi};
  assign o_imm_s = {{(XLEN-12){i_hi[11]}}, i_hi[11:5], i_lo};
  assign o_imm_b = {{(XLEN-13){i_hi[11]}}, i_hi[11], i_lo[0], i_hi[10:5], i_lo[4:1], 1'b0};
endmodule

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle control unit for a minimal RV64 subset
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PC_W    = 7,
  parameter int X0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     instr,
  input  logic            zero,
  output logic [PC_W-1:0] endr,
  output logic [4:0]      Ra,
  output logic [4:0]      Rb,
  output logic [4:0]      Rw,
  output logic            WeR,
  output logic            WeM,
  output logic            soma_ou_subtrai,
  output logic            subtraindo,
  output logic [1:0]      escolhe_entrada1,
  output logic [1:0]      escolhe_entrada2,
  output logic [XLEN-1:0] constante,
  output logic            sel_dinR,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);
  localparam logic [PC_W-1:0] PC_ONE = 1;
  state_t r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc, w_pc_inc, w_boff;
  logic [31:0] r_ir, w_ir;
  logic r_halted, r_illegal, w_halted, w_illegal;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b;
  kind_t w_kind_in, w_kind_ir;
  logic w_stop, w_ldst, w_beq;

  gerador_imediato #(.XLEN(XLEN)) u_imm (
    .i_hi   (r_ir[31:20]),
    .i_lo   (r_ir[11:7]),
    .o_imm_i(w_imm_i),
    .o_imm_s(w_imm_s),
    .o_imm_b(w_imm_b)
  );

  assign w_kind_in = classify(instr);
  assign w_kind_ir = classify(r_ir);
  assign w_stop = (w_kind_in == K_EBRK) || (w_kind_in == K_ILL);
  assign w_ldst = (w_kind_ir == K_LD) || (w_kind_ir == K_SD);
  assign w_beq = (w_kind_ir == K_BEQ);
  assign w_pc_inc = r_pc + PC_ONE;
  // Branch offset is a byte offset; the PC counts instruction words, so drop two bits
  assign w_boff = w_imm_b[PC_W+1:2];
  assign endr = r_pc;
  assign Ra = r_ir[19:15];
  assign Rb = r_ir[24:20];
  assign Rw = r_ir[11:7];
  assign constante = (r_ir[6:0] == OPC_ST) ? w_imm_s : (r_ir[6:0] == OPC_BR) ? w_imm_b : w_imm_i;
  assign busy = (r_state != IDLE) && (r_state != HALT);
  assign halted = r_halted;
  assign illegal = r_illegal;

  // State, PC, IR and status registers; reset drops everything mid-instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_ir <= '0;
      r_halted <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc <= w_pc;
      r_ir <= w_ir;
      r_halted <= w_halted;
      r_illegal <= w_illegal;
    end
  end

  // Next-state, PC update and per-state control outputs
  always_comb begin
    w_next = r_state;
    w_pc = r_pc;
    w_ir = r_ir;
    w_halted = r_halted;
    w_illegal = r_illegal;
    WeR = 1'b0;
    WeM = 1'b0;
    soma_ou_subtrai = 1'b0;
    subtraindo = 1'b0;
    escolhe_entrada1 = SEL_B;
    escolhe_entrada2 = SEL_B;
    sel_dinR = 1'b0;
    case (r_state)
      IDLE: begin
        w_pc = '0;
        w_next = start ? FETCH : IDLE;
      end
      FETCH: w_next = DECODE;
      DECODE: begin
        w_ir = instr;
        w_halted = w_stop;
        w_illegal = (w_kind_in == K_ILL);
        w_next = w_stop ? HALT : EXEC;
      end
      EXEC: begin
        escolhe_entrada1 = SEL_A;
        escolhe_entrada2 = (w_kind_ir == K_ADD || w_kind_ir == K_SUB || w_beq) ? SEL_B : SEL_C;
        soma_ou_subtrai = 1'b1;
        subtraindo = (w_kind_ir == K_SUB) || w_beq;
        w_next = w_ldst ? MEM : w_beq ? FETCH : WB;
        w_pc = w_beq ? (zero ? r_pc + w_boff : w_pc_inc) : r_pc;
      end
      MEM: begin
        escolhe_entrada1 = SEL_A;
        escolhe_entrada2 = SEL_C;
        soma_ou_subtrai = 1'b1;
        WeM = (w_kind_ir == K_SD);
        w_next = (w_kind_ir == K_SD) ? FETCH : WB;
        w_pc = (w_kind_ir == K_SD) ? w_pc_inc : r_pc;
      end
      WB: begin
        WeR = !(X0_ZERO != 0 && Rw == 5'd0);
        sel_dinR = (w_kind_ir == K_LD);
        w_next = FETCH;
        w_pc = w_pc_inc;
      end
      HALT: begin
        w_next = start ? FETCH : HALT;
        w_pc = start ? '0 : r_pc;
        w_halted = start ? 1'b0 : r_halted;
        w_illegal = start ? 1'b0 : r_illegal;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule
